fp_rf_sb: RTL
=============

// Module: fp_rf_sb
// PURPOSE
//  Parametrised FP register file with integrated scoreboard, successor to the single-write FP RF.
//  Provides NRD combinational read ports, two write-back ports (FP ALU, memory load) and same-cycle
//  write-to-read bypass. Tracks a per-register pending bit for multicycle FP ops and raises a
//  decode-stage stall on RAW/WAW hazards. Sits between ID (reads, issue) and WB (writes).
// PARAMETERS
//  DATA_W     32  register width in bits
//  NREG       32  number of FP registers (power of 2)
//  NRD        3   number of read ports (rs, rt, store-data)
//  ZERO_HARD  0   1: register 0 reads 0 and ignores writes and issues; 0: register 0 is ordinary
// PORTS  (AW = $clog2(NREG))
//  clk         in   1         clock, all state updates on rising edge
//  rst         in   1         synchronous reset, active-high
//  rd_en       in   NRD       read port i in use this cycle (qualifies hazard check only)
//  rd_addr     in   NRD*AW    packed read addresses, port i at [i*AW +: AW]
//  rd_data     out  NRD*DATA_W packed read data (combinational)
//  wb_en       in   2         write enable: [0] FP ALU result, [1] memory load
//  wb_addr     in   2*AW      packed write addresses
//  wb_data     in   2*DATA_W  packed write data
//  iss_valid   in   1         FP op with destination issues this cycle (ignored while stall=1)
//  iss_addr    in   AW        destination of issuing op
//  stall       out  1         hazard: decode must hold; combinational
//  busy_cnt    out  AW+1      registered count of pending registers
// BEHAVIOUR
//  Reset (rst=1 at edge): all NREG registers <= 0, all pending bits <= 0, busy_cnt <= 0. Reset wins
//   over every simultaneous write/issue. Outputs after reset: rd_data=0, stall=0, busy_cnt=0.
//  Write: at edge, wb_en[k] writes wb_data[k] to wb_addr[k]. Both ports same address: port 1 (load)
//   wins. ZERO_HARD=1 and addr 0: write dropped.
//  Read (0 latency): rd_data[i] = wb_data[1] if wb_en[1] & addr match; else wb_data[0] if wb_en[0]
//   & match; else array contents. ZERO_HARD=1 and addr 0: 0 regardless of bypass.
//  Pending bit p[r]: set at edge by accepted issue (iss_valid & ~stall) to r; cleared at edge by any
//   wb_en[k] to r. Set and clear same r same cycle: set wins (new producer). ZERO_HARD=1: p[0] stays 0.
//  Effective pending pe[r] = p[r] & ~(any wb_en[k] to r this cycle) (write-back bypasses hazard).
//  stall = OR over i of (rd_en[i] & pe[rd_addr[i]]) | (iss_valid & pe[iss_addr]) (WAW).
//  busy_cnt: next = busy_cnt + (set & ~p[r_set]) - (number of distinct set bits cleared, excluding
//   one re-set by the issue). Must always equal popcount(p); never wraps (max NREG).
//  Write to a non-pending register is legal (single-cycle op path); it clears nothing extra.
//  No storage beyond array, p[], busy_cnt; no FSM beyond scoreboard bits. Reset mid-operation
//   discards all pending state; in-flight results arriving after reset are written normally.
// STRUCTURE
//  Package fp_rf_pkg: DATA_W/NREG defaults, AW localparam, WB_ALU=0 / WB_LOAD=1 port indices.
//  Sub-module fp_scoreboard (p[], pe[], stall, busy_cnt); top holds the array and bypass muxes.
//  Address-match and priority logic written as generate loops over NRD and the 2 write ports.
// TESTING
//  1 Reset: preload f5=0x3F800000, assert rst 1 cycle -> rd f5=0, busy_cnt=0, stall=0.
//  2 Bypass: wb_en=01 f3=0x40490FDB, rd_addr0=f3 same cycle -> rd_data0=0x40490FDB; next cycle same.
//  3 Port conflict: wb_en=11 both to f7, ALU 0x11111111, load 0x22222222 -> f7=0x22222222.
//  4 RAW: issue f4; next cycle rd_en0 on f4 -> stall=1, busy_cnt=1; wb_en[0] to f4 that cycle ->
//    stall=0, rd_data0=wb_data; after edge busy_cnt=0.
//  5 WAW/set-wins: f9 pending, iss f9 -> stall=1; f9 pending, wb f9 + iss f9 same cycle ->
//    stall=0, p[9] stays 1, busy_cnt unchanged.
//  6 ZERO_HARD=1: issue/write f0=0xDEADBEEF -> rd f0=0, stall never asserts on f0, busy_cnt=0.

Source files
------------

// File: rtl/fp_rf_pkg.sv
// rtl/fp_rf_pkg.sv - shared constants for the FP register file with scoreboard
// Purpose: default geometry and write-back port indices used by fp_rf_sb and fp_scoreboard.
// Ports: none (package).
package fp_rf_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int NREG_DEF   = 32;
   localparam int AW_DEF     = $clog2(NREG_DEF);

   // Write-back port indices; the load port has priority on address collisions.
   localparam int WB_ALU  = 0;
   localparam int WB_LOAD = 1;
   localparam int NWB     = 2;
endpackage

// File: rtl/fp_scoreboard.sv
// rtl/fp_scoreboard.sv - per-register pending bits, hazard stall and busy count
// Purpose: tracks FP registers awaiting a multicycle result and flags RAW/WAW hazards at decode.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rd_en, rd_addr           read ports participating in the RAW check
//   wb_en, wb_addr           write-back ports (clear pending, bypass the hazard)
//   iss_valid, iss_addr      issuing op destination (sets pending, WAW check)
//   stall                    combinational hazard indication
//   busy_cnt                 registered number of pending registers
module fp_scoreboard
   import fp_rf_pkg::*;
#(
   parameter int NREG      = NREG_DEF,
   parameter int NRD       = 3,
   parameter int ZERO_HARD = 0,
   parameter int AW        = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD-1:0]      rd_en,
   input  logic [NRD*AW-1:0]   rd_addr,
   input  logic [NWB-1:0]      wb_en,
   input  logic [NWB*AW-1:0]   wb_addr,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_addr,
   output logic                stall,
   output logic [AW:0]         busy_cnt
);

   logic [NREG-1:0] p_q, p_d;
   logic [AW:0]     busy_q, busy_d;
   logic [NREG-1:0] wb_hit;
   logic [NREG-1:0] pe;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;
   logic [AW:0]     clr_cnt;
   logic            iss_acc;
   logic            set_new;

   always_comb begin
      wb_hit = '0;
      for (int k = 0; k < NWB; k++) begin
         if (wb_en[k]) wb_hit[wb_addr[k*AW +: AW]] = 1'b1;
      end
   end

   // A result arriving this cycle resolves the hazard immediately.
   assign pe = p_q & ~wb_hit;

   always_comb begin
      stall = iss_valid & pe[iss_addr];
      for (int i = 0; i < NRD; i++) begin
         if (rd_en[i] && pe[rd_addr[i*AW +: AW]]) stall = 1'b1;
      end
   end

   assign iss_acc = iss_valid & ~stall & ~((ZERO_HARD != 0) && (iss_addr == '0));

   always_comb begin
      set_mask = '0;
      if (iss_acc) set_mask[iss_addr] = 1'b1;
   end

   // A register cleared and re-issued in the same cycle stays pending (new producer).
   assign p_d     = (p_q & ~wb_hit) | set_mask;
   assign set_new = iss_acc & ~p_q[iss_addr];
   assign clr_mask = p_q & wb_hit & ~set_mask;

   always_comb begin
      clr_cnt = '0;
      for (int r = 0; r < NREG; r++) begin
         if (clr_mask[r]) clr_cnt = clr_cnt + 1'b1;
      end
   end

   assign busy_d   = busy_q + {{AW{1'b0}}, set_new} - clr_cnt;
   assign busy_cnt = busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q    <= '0;
         busy_q <= '0;
      end else begin
         p_q    <= p_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/fp_rf_sb.sv
// rtl/fp_rf_sb.sv - FP register file with dual write-back, read bypass and scoreboard
// Purpose: NRD combinational read ports, ALU and load write-back ports, same-cycle bypass,
//          decode stall from the integrated scoreboard.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rd_en, rd_addr, rd_data  packed read ports (rd_en only qualifies the hazard check)
//   wb_en, wb_addr, wb_data  packed write-back ports: [0] FP ALU, [1] memory load
//   iss_valid, iss_addr      FP op issuing with a destination
//   stall                    combinational decode hold
//   busy_cnt                 registered count of pending registers
module fp_rf_sb
   import fp_rf_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int NREG      = NREG_DEF,
   parameter int NRD       = 3,
   parameter int ZERO_HARD = 0,
   parameter int AW        = $clog2(NREG)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRD-1:0]        rd_en,
   input  logic [NRD*AW-1:0]     rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   input  logic [NWB-1:0]        wb_en,
   input  logic [NWB*AW-1:0]     wb_addr,
   input  logic [NWB*DATA_W-1:0] wb_data,
   input  logic                  iss_valid,
   input  logic [AW-1:0]         iss_addr,
   output logic                  stall,
   output logic [AW:0]           busy_cnt
);

   logic [DATA_W-1:0] mem_q [NREG];
   logic [DATA_W-1:0] mem_d [NREG];

   // Ports applied in index order so the load port overwrites the ALU port on a collision.
   always_comb begin
      mem_d = mem_q;
      for (int k = 0; k < NWB; k++) begin
         if (wb_en[k] && !((ZERO_HARD != 0) && (wb_addr[k*AW +: AW] == '0))) begin
            mem_d[wb_addr[k*AW +: AW]] = wb_data[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) mem_q[r] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]     addr;
      logic [NWB-1:0]    hit;
      logic [DATA_W-1:0] rd_val;

      assign addr = rd_addr[i*AW +: AW];

      for (genvar k = 0; k < NWB; k++) begin : g_wb
         assign hit[k] = wb_en[k] && (wb_addr[k*AW +: AW] == addr);
      end

      always_comb begin
         rd_val = mem_q[addr];
         if (hit[WB_ALU])  rd_val = wb_data[WB_ALU*DATA_W +: DATA_W];
         if (hit[WB_LOAD]) rd_val = wb_data[WB_LOAD*DATA_W +: DATA_W];
         if ((ZERO_HARD != 0) && (addr == '0)) rd_val = '0;
      end

      assign rd_data[i*DATA_W +: DATA_W] = rd_val;
   end

   fp_scoreboard #(
      .NREG      (NREG),
      .NRD       (NRD),
      .ZERO_HARD (ZERO_HARD),
      .AW        (AW)
   ) u_sb (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .stall     (stall),
      .busy_cnt  (busy_cnt)
   );

endmodule
